// File: rtl/core_pkg.sv
// Shared constants and the writeback request type used by the register-file write front end.
package core_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of writeback requests; full/empty are derived by the caller from count.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage is not reset: entries are only observable through count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and LSU results onto the single register-file write port; ALU has priority and
// displaced LSU results wait in an in-order FIFO.
module regfile_writeback
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              busy
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Handshake: an LSU result transfers on a cycle where lsu_valid && lsu_ready; lsu_ready
  // depends only on reset and queue occupancy, never on either valid. ALU results have no
  // ready and are always taken.
  logic    lsu_acc;
  logic    fifo_push;
  logic    fifo_pop;
  logic    sel_valid;
  wb_req_t sel_req;
  wb_req_t lsu_req;
  wb_req_t fifo_head;

  assign lsu_ready = !rst && (fifo_count < DEPTH_C);
  assign lsu_acc   = lsu_valid && lsu_ready;
  assign lsu_req   = '{rd: lsu_rd, data: lsu_data};

  always_comb begin
    sel_valid = 1'b0;
    sel_req   = fifo_head;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_req   = '{rd: alu_rd, data: alu_data};
      fifo_push = lsu_acc;
    end else if (fifo_count != '0) begin
      sel_valid = 1'b1;
      sel_req   = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = lsu_acc;
    end else if (lsu_acc) begin
      // Empty queue: bypass straight to the write port so order is still preserved.
      sel_valid = 1'b1;
      sel_req   = lsu_req;
    end
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lsu_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // x0 results are consumed like any other but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write_en <= sel_valid && (sel_req.rd != '0);
      if (sel_valid) begin
        rf_write_reg  <= sel_req.rd;
        rf_write_data <= sel_req.data;
      end
    end
  end

  assign busy = (fifo_count != '0) || rf_write_en;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_regfile_writeback;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int W     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              lsu_valid = 1'b0;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd = '0;
  logic [DATA_W-1:0] lsu_data = '0;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .fifo_count    (fifo_count),
    .busy          (busy)
  );

  int   tests = 0;
  int   fails = 0;
  logic chk_on = 1'b0;

  logic [W-1:0] exp_q[$];   // writes the register file must see, in order
  logic [W-1:0] model_q[$]; // LSU results the model holds back behind ALU traffic
  logic         last_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_model_q(input logic [ADDR_W-1:0] rd);
    foreach (model_q[i]) if (model_q[i][W-1 -: ADDR_W] == rd) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model (decides each cycle, mid-cycle) ----------------
  always @(negedge clk) begin : model
    logic         acc;
    logic         have;
    logic [W-1:0] w;
    logic [W-1:0] l;
    if (chk_on) begin
      chk("lsu_ready", 64'(lsu_ready), 64'(!rst && model_q.size() < DEPTH));
      chk("fifo_count", 64'(fifo_count), 64'(model_q.size()));
      chk("busy", 64'(busy), 64'(model_q.size() != 0 || last_en));
    end
    if (rst) begin
      model_q.delete();
      last_en = 1'b0;
    end else begin
      acc  = lsu_valid && (model_q.size() < DEPTH);
      l    = {lsu_rd, lsu_data};
      have = 1'b0;
      w    = '0;
      if (acc && lsu_rd != '0 && chk_on)
        chk("waw_precondition", 64'(in_model_q(lsu_rd) || (alu_valid && alu_rd == lsu_rd)), 64'(0));
      if (alu_valid) begin
        w = {alu_rd, alu_data}; have = 1'b1;
        if (acc) model_q.push_back(l);
      end else if (model_q.size() != 0) begin
        w = model_q.pop_front(); have = 1'b1;
        if (acc) model_q.push_back(l);
      end else if (acc) begin
        w = l; have = 1'b1;
      end
      last_en = have && (w[W-1 -: ADDR_W] != '0);
      if (last_en) exp_q.push_back(w);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    logic [W-1:0] e;
    #1;
    if (chk_on) begin
      chk("rf_write_en", 64'(rf_write_en), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rf_write_en === 1'b1) begin
          chk("rf_write_reg", 64'(rf_write_reg), 64'(e[W-1 -: ADDR_W]));
          chk("rf_write_data", 64'(rf_write_data), 64'(e[DATA_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                       input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ld,
                       output logic accepted);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    accepted = lv && lsu_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, a);
  endtask

  function automatic logic [ADDR_W-1:0] pick_rd(input logic [ADDR_W-1:0] avoid);
    logic [ADDR_W-1:0] rd;
    do rd = ADDR_W'($urandom_range(0, 31));
    while (rd != '0 && (rd == avoid || in_model_q(rd)));
    return rd;
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    logic              acc;
    int                k;
    logic              av;
    logic              lv;
    logic [ADDR_W-1:0] ard;
    logic [ADDR_W-1:0] lrd;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // single ALU write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, acc);
    idle(1);

    // ALU and LSU in the same cycle: LSU goes through the queue
    drive(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd7, 32'h0000_0777, acc);
    idle(3);

    // ALU streaming while LSU keeps offering: queue fills, ready drops, then drains in order
    k = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ADDR_W'(10 + i), 32'hA1A1_0000 + 32'(i),
            1'b1, ADDR_W'(20 + k), 32'hB2B2_0000 + 32'(k), acc);
      if (acc) k++;
    end
    idle(6);

    // x0 destinations: consumed but never written
    drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, '0, acc);
    idle(1);
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_5678, acc);
    drive(1'b1, 5'd4, 32'h0000_0444, 1'b1, 5'd0, 32'h0000_9ABC, acc);
    idle(3);

    // reset in the middle of traffic with two results queued
    drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd8, 32'h8888_8888, acc);
    drive(1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd9, 32'h9999_9999, acc);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hCCCC_CCCC, acc);
    rst = 1'b0;
    idle(3);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      av  = ($urandom_range(0, 9) < 4);
      lv  = ($urandom_range(0, 9) < 5);
      ard = pick_rd('0);
      lrd = pick_rd(av ? ard : 5'd0);
      drive(av, ard, $urandom, lv, lrd, $urandom, acc);
    end
    idle(8);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
